// File: rtl/fp_to_int_converter.sv
// fp_to_int_converter: IEEE-754 single to int32, truncating toward zero.
// Iterative shifter, one conversion in flight, valid/ready on both sides.
module fp_to_int_converter (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] a_i,
  input  logic        vld_i,
  output logic        rdy_o,
  output logic [31:0] result_o,
  output logic        status_o,
  output logic        ovf_o,
  output logic        vld_o,
  input  logic        rdy_i
);

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] mant;
  } float_point_num;

  typedef enum logic {
    OK         = 1'b0,
    NAN_OR_INF = 1'b1
  } num_status;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    SIGN,
    DONE
  } state_t;

  localparam logic [31:0] INT_MAX = 32'h7FFF_FFFF;
  localparam logic [31:0] INT_MIN = 32'h8000_0000;

  float_point_num op;
  state_t         state_q;
  state_t         state_d;
  logic [31:0]    mag_q;
  logic [4:0]     cnt_q;
  logic           left_q;
  logic           sign_q;
  logic [31:0]    result_q;
  num_status      status_q;
  logic           ovf_q;

  logic           accept;
  logic           is_small;
  logic           is_spec;
  logic           is_big;
  logic           is_norm;
  logic           dir_left;
  logic [4:0]     n_init;

  assign op       = a_i;
  assign rdy_o    = (state_q == IDLE) && !rst_i;
  assign vld_o    = (state_q == DONE);
  assign accept   = vld_i && rdy_o;
  assign result_o = result_q;
  assign status_o = status_q;
  assign ovf_o    = ovf_q;

  // Classify the operand; the four classes are mutually exclusive.
  // n = |exp - 150| fits in 5 bits, so mod-32 arithmetic on exp[4:0]
  // (150 mod 32 = 22) gives the exact count.
  always_comb begin
    is_small = op.exp < 8'd127;
    is_spec  = op.exp == 8'd255;
    is_big   = (op.exp >= 8'd158) && !is_spec;
    is_norm  = !is_small && (op.exp < 8'd158);
    dir_left = op.exp > 8'd150;
    n_init   = dir_left ? (op.exp[4:0] - 5'd22)
                        : (5'd22 - op.exp[4:0]);
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (!is_norm)           state_d = DONE;
          else if (n_init == '0)  state_d = SIGN;
          else                    state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_q == 5'd1) state_d = SIGN;
      end
      SIGN: state_d = DONE;
      DONE: begin
        if (rdy_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand capture, shifting and result formation.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mag_q    <= '0;
      cnt_q    <= '0;
      left_q   <= 1'b0;
      sign_q   <= 1'b0;
      result_q <= '0;
      status_q <= OK;
      ovf_q    <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            unique case (1'b1)
              is_small: begin
                result_q <= '0;
                status_q <= OK;
                ovf_q    <= 1'b0;
              end
              is_spec: begin
                status_q <= NAN_OR_INF;
                ovf_q    <= 1'b0;
                if (op.sign || (op.mant != '0))
                  result_q <= INT_MIN;
                else
                  result_q <= INT_MAX;
              end
              is_big: begin
                status_q <= OK;
                if (op.sign) begin
                  result_q <= INT_MIN;
                  ovf_q    <= (op.exp != 8'd158) || (op.mant != '0);
                end else begin
                  result_q <= INT_MAX;
                  ovf_q    <= 1'b1;
                end
              end
              is_norm: begin
                mag_q  <= {8'b0, 1'b1, op.mant};
                cnt_q  <= n_init;
                left_q <= dir_left;
                sign_q <= op.sign;
              end
              default: ;
            endcase
          end
        end
        SHIFT: begin
          mag_q <= left_q ? (mag_q << 1) : (mag_q >> 1);
          cnt_q <= cnt_q - 5'd1;
        end
        SIGN: begin
          result_q <= sign_q ? (-mag_q) : mag_q;
          status_q <= OK;
          ovf_q    <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_to_int_converter.sv
// tb_fp_to_int_converter: directed vectors for fp_to_int_converter.
// Checks result, status, overflow, latency, backpressure and reset.
module tb_fp_to_int_converter;

  logic        clk;
  logic        rst_i;
  logic [31:0] a_i;
  logic        vld_i;
  logic        rdy_o;
  logic [31:0] result_o;
  logic        status_o;
  logic        ovf_o;
  logic        vld_o;
  logic        rdy_i;

  int checks = 0;
  int errors = 0;

  fp_to_int_converter dut (
    .clk_i    (clk),
    .rst_i    (rst_i),
    .a_i      (a_i),
    .vld_i    (vld_i),
    .rdy_o    (rdy_o),
    .result_o (result_o),
    .status_o (status_o),
    .ovf_o    (ovf_o),
    .vld_o    (vld_o),
    .rdy_i    (rdy_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Present one operand at a negedge; returns just after the accept edge.
  task automatic start(input logic [31:0] a);
    @(negedge clk);
    chk("rdy_idle", {31'b0, rdy_o}, 32'd1);
    a_i   = a;
    vld_i = 1'b1;
    @(posedge clk);
    #1;
    vld_i = 1'b0;
    a_i   = 32'hFFFF_FFFF;
  endtask

  task automatic wait_done(input string tag, input int lat);
    int e;
    e = 1;
    while (!vld_o && e < 40) begin
      @(posedge clk);
      #1;
      e++;
    end
    chk({tag, "_lat"}, e, lat);
  endtask

  task automatic expect_out(input string tag, input logic [31:0] res,
                            input logic st, input logic ov);
    chk({tag, "_res"}, result_o, res);
    chk({tag, "_st"}, {31'b0, status_o}, {31'b0, st});
    chk({tag, "_ovf"}, {31'b0, ovf_o}, {31'b0, ov});
  endtask

  task automatic convert(input string tag, input logic [31:0] a,
                         input logic [31:0] res, input logic st,
                         input logic ov, input int lat);
    start(a);
    wait_done(tag, lat);
    expect_out(tag, res, st, ov);
    @(posedge clk);
    #1;
    chk({tag, "_ret"}, {31'b0, vld_o}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    rst_i = 1'b1;
    vld_i = 1'b0;
    a_i   = '0;
    rdy_i = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_rdy", {31'b0, rdy_o}, 32'd0);
    chk("rst_vld", {31'b0, vld_o}, 32'd0);
    expect_out("rst", 32'h0, 1'b0, 1'b0);
    rst_i = 1'b0;
    #1;
    chk("rel_rdy", {31'b0, rdy_o}, 32'd1);

    convert("one",    32'h3F80_0000, 32'h0000_0001, 1'b0, 1'b0, 25);
    convert("p2_30",  32'h4E80_0000, 32'h4000_0000, 1'b0, 1'b0, 9);
    convert("n5_75",  32'hC0B8_0000, 32'hFFFF_FFFB, 1'b0, 1'b0, 23);
    convert("half",   32'h3F00_0000, 32'h0000_0000, 1'b0, 1'b0, 1);
    convert("zero",   32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 1);
    convert("p2_23",  32'h4B00_0000, 32'h0080_0000, 1'b0, 1'b0, 2);
    convert("max30",  32'h4EFF_FFFF, 32'h7FFF_FF80, 1'b0, 1'b0, 9);
    convert("n1_5",   32'hBFC0_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 25);
    convert("min",    32'hCF00_0000, 32'h8000_0000, 1'b0, 1'b0, 1);
    convert("p2_31",  32'h4F00_0000, 32'h7FFF_FFFF, 1'b0, 1'b1, 1);
    convert("nbig",   32'hCF00_0001, 32'h8000_0000, 1'b0, 1'b1, 1);
    convert("huge",   32'h7F7F_FFFF, 32'h7FFF_FFFF, 1'b0, 1'b1, 1);
    convert("nan",    32'h7FC0_0000, 32'h8000_0000, 1'b1, 1'b0, 1);
    convert("pinf",   32'h7F80_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 1);
    convert("ninf",   32'hFF80_0000, 32'h8000_0000, 1'b1, 1'b0, 1);

    rdy_i = 1'b0;
    start(32'h4E80_0000);
    wait_done("bp", 9);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      vld_i = 1'b1;
      a_i   = 32'h3F80_0000;
      @(posedge clk);
      #1;
      chk("bp_vld", {31'b0, vld_o}, 32'd1);
      chk("bp_res", result_o, 32'h4000_0000);
      chk("bp_rdy", {31'b0, rdy_o}, 32'd0);
    end
    vld_i = 1'b0;
    @(negedge clk);
    rdy_i = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_rel_vld", {31'b0, vld_o}, 32'd0);
    chk("bp_rel_rdy", {31'b0, rdy_o}, 32'd1);
    @(posedge clk);
    #1;
    chk("bp_idle", {31'b0, vld_o}, 32'd0);

    start(32'h3F80_0000);
    repeat (5) @(posedge clk);
    #1;
    rst_i = 1'b1;
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    seen = 0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (vld_o) seen = 1;
    end
    chk("mid_novld", seen, 0);
    chk("mid_rdy", {31'b0, rdy_o}, 32'd1);
    convert("ten", 32'h4120_0000, 32'h0000_000A, 1'b0, 1'b0, 22);

    rdy_i = 1'b0;
    start(32'h7F80_0000);
    wait_done("dn", 1);
    rst_i = 1'b1;
    #1;
    chk("dn_rst_rdy", {31'b0, rdy_o}, 32'd0);
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    rdy_i = 1'b1;
    chk("dn_vld", {31'b0, vld_o}, 32'd0);
    expect_out("dn", 32'h0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
